apb_master: RTL and testbench
=============================

# apb_master

APB initiator that turns a simple valid/ready command stream into single APB transfers and returns a read-data/error response per command. It sits between an internal controller (CPU bridge, config sequencer) and the APB register slaves in this design. It decodes the top address bits into a one-hot `psel`, and it handles wait states (`pready`) and error responses (`pslverr`). Transfers are non-pipelined: only one transfer is in flight at a time.

## Interface
Parameters:
- `ADDR_W`, 16, width of the command address and `paddr`.
- `DATA_W`, 32, width of the data buses.
- `NSLV`, 4, number of APB slaves. `SEL_W = max(1, clog2(NSLV))`.
- `TIMEOUT`, 255, maximum number of ACCESS cycles. Used only when the timeout feature is compiled in.

Ports:
- `pclk`  in  1  APB clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  clock-gating qualifier. When low, all state holds.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when both `cmd_valid` and `cmd_ready` are high on a clock edge.
- `cmd_addr`  in  ADDR_W  byte address. Bits `[ADDR_W-1 -: SEL_W]` hold the slave index.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when both `rsp_valid` and `rsp_ready` are high on a clock edge.
- `rsp_rdata`  out  DATA_W  read data. Always 0 for writes and for errors.
- `rsp_err`  out  1  `pslverr`, decode error, or timeout.
- `paddr`  out  ADDR_W  APB address.
- `pwrite`  out  1  APB write strobe.
- `psel`  out  NSLV  one-hot slave select.
- `penable`  out  1  APB access phase.
- `pwdata`  out  DATA_W  APB write data.
- `prdata`  in  DATA_W  OR of all slave read buses. Unselected slaves drive 0.
- `pready`  in  NSLV  per-slave ready.
- `pslverr`  in  NSLV  per-slave error.

## Operation
- The FSM has four states: IDLE, SETUP, ACCESS, RESP. All outputs except `cmd_ready` are registered.
- `cmd_ready = enable & (state == IDLE)`.
- **IDLE, on command accept:**
  - Latch `cmd_addr`, `cmd_write` and `cmd_wdata`, and compute the slave index.
  - If the index is below `NSLV`: drive `paddr`, `pwrite`, `pwdata` and `psel[idx] = 1`, then go to SETUP.
  - If the index is `>= NSLV`: `psel` stays 0, `rsp_err` = 1, `rsp_rdata` = 0, go directly to RESP.
- **SETUP:** `penable` goes to 1, then go to ACCESS.
- **ACCESS:** wait while `pready[idx] = 0`. When `pready[idx] = 1`:
  - Capture `rsp_rdata = pwrite ? 0 : prdata` and `rsp_err = pslverr[idx]`.
  - Clear `psel` and `penable`, set `rsp_valid` = 1, go to RESP.
- **ACCESS holds:** `paddr`, `pwrite` and `pwdata` stay stable for the whole transfer, from SETUP through the final ACCESS cycle.
- **RESP:** hold `rsp_valid`, `rsp_rdata` and `rsp_err` until `rsp_ready`. Then clear `rsp_valid` and go to IDLE.
- `pready` and `pslverr` are ignored for non-selected slaves and outside the ACCESS state.
- **Reset values:** every output is 0 — `psel`, `penable`, `paddr`, `pwrite`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `cmd_ready`.
- **Reset mid-transfer:** all outputs clear immediately (asynchronously), the state returns to IDLE, and the in-flight command is dropped with no response.

## Timing
- Command accepted at edge 0 → SETUP in cycle 1 (`psel` = 1, `penable` = 0) → ACCESS in cycle 2 (`penable` = 1).
- With zero wait states, `rsp_valid` is high in cycle 3. Each low `pready` cycle adds one cycle.
- Minimum command-to-command spacing is 4 cycles, with `rsp_ready` held at 1.
- Decode error: `rsp_valid` is high in cycle 1 after the accept.
- `enable` = 0 freezes the state, outputs and timeout counter. APB signals stay asserted; `pready` is not sampled.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- **Defined:**
  - An 8–16-bit counter clears on entry to ACCESS and increments each ACCESS cycle in which `pready[idx]` = 0.
  - When the counter reaches `TIMEOUT`, the transfer terminates: `psel` and `penable` clear, `rsp_err` = 1, `rsp_rdata` = 0, and the FSM enters RESP.
  - If `pready` arrives in the same cycle the counter reaches `TIMEOUT`, `pready` wins and the transfer completes normally.
- **Undefined:** ACCESS waits indefinitely. There is no counter logic, and `TIMEOUT` is unused.

## Structure
- Shared package `apb_pkg` holds:
  - the state enum typedef `apb_mst_state_t` (IDLE, SETUP, ACCESS, RESP);
  - the default `ADDR_W`/`DATA_W` constants;
  - a `sel_w(nslv)` helper function.
- Sub-module `apb_master_timeout`: a counter with clear, count, enable and `expired` signals. It is instantiated only under `APB_MASTER_TIMEOUT_EN`.

## Test plan
- **Zero-wait write:** write `0x4004`, data `0xDEADBEEF`, `pready` = 1111. Expect `psel` = 0010 in cycle 1, `penable` in cycle 2, `pwdata` = `0xDEADBEEF` held in both cycles, `rsp_valid` in cycle 3 with err = 0 and rdata = 0.
- **Read with wait states:** read `0x8008`, `pready[2]` low for 3 ACCESS cycles, `prdata` = `0x12345678`. Expect ACCESS to last 4 cycles and `rsp_rdata` = `0x12345678`, err = 0.
- **Slave error:** `pslverr[3]` = 1 with `pready[3]` on a read of `0xC000`. Expect `rsp_err` = 1 and `rsp_rdata` = `0x12345678` captured.
- **Response backpressure:** hold `rsp_ready` = 0 for 5 cycles. Expect `rsp_valid` and data held, `cmd_ready` = 0, and no new `psel` while a second command is pending.
- **Decode error:** `NSLV` = 3, address `0xC000`. Expect `psel` to stay 000 and `rsp_valid`/`rsp_err` = 1 in cycle 1. Separately, assert `reset_n` during ACCESS and expect all outputs at 0 with no response issued.
- **Timeout:** with `APB_MASTER_TIMEOUT_EN` and `TIMEOUT` = 8, drive `pready` = 0 forever. Expect `psel` to drop after 8 ACCESS cycles with `rsp_err` = 1. Without the macro, ACCESS is still held after 100 cycles.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB initiator: FSM state type, default bus widths,
// and the slave-select width helper.
package apb_pkg;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_mst_state_t;

    // Number of top address bits used as the slave index (at least one).
    function automatic int sel_w(input int nslv);
        return (nslv <= 1) ? 1 : $clog2(nslv);
    endfunction

endpackage

// File: rtl/apb_master_if.sv
// Command/response stream plus APB bus bundle seen by the APB initiator.
// The master modport is the initiator's view; slave is the environment's view.
interface apb_master_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W,
    parameter int NSLV   = 4
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [NSLV-1:0]   psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic [NSLV-1:0]   pready;
    logic [NSLV-1:0]   pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwrite, psel, penable, pwdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwrite, psel, penable, pwdata
    );

endinterface

// File: rtl/apb_master_timeout.sv
// ACCESS-phase watchdog counter; only instantiated when APB_MASTER_TIMEOUT_EN is defined.
// expired is high in the counting cycle that would bring the count up to TIMEOUT.
module apb_master_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic pclk,
    input  logic reset_n,
    input  logic enable,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int RAW_W = $clog2(TIMEOUT + 1);
    localparam int CNT_W = (RAW_W < 8) ? 8 : ((RAW_W > 16) ? 16 : RAW_W);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (enable) begin
            if (clear) begin
                cnt <= '0;
            end else if (count && !expired) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign expired = count && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master.sv
// Non-pipelined APB initiator: one valid/ready command in, one APB transfer out, one response back.
// Optional ACCESS timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int NSLV    = 4,
    parameter int TIMEOUT = 255
) (
    input logic          pclk,
    input logic          reset_n,
    input logic          enable,
    apb_master_if.master bus
);

    localparam int SEL_W = sel_w(NSLV);

    apb_mst_state_t    state, state_nxt;
    logic [NSLV-1:0]   psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [SEL_W-1:0]  dec_idx;
    logic              dec_ok;
    logic              sel_ready;
    logic              sel_err;
    logic              to_expired;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("apb_master: TIMEOUT must be at least 1");
    end

    assign dec_idx = bus.cmd_addr[ADDR_W-1 -: SEL_W];
    assign dec_ok  = int'(dec_idx) < NSLV;

    // psel is one-hot, so masking with it picks the addressed slave's handshake.
    assign sel_ready = |(bus.pready & psel_q);
    assign sel_err   = |(bus.pslverr & psel_q);

`ifdef APB_MASTER_TIMEOUT_EN
    apb_master_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .pclk   (pclk),
        .reset_n(reset_n),
        .enable (enable),
        .clear  (state == SETUP),
        .count  ((state == ACCESS) && !sel_ready),
        .expired(to_expired)
    );
`else
    assign to_expired = 1'b0;
`endif

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_nxt   = state;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b0;
                        if (dec_ok) begin
                            paddr_d   = bus.cmd_addr;
                            pwrite_d  = bus.cmd_write;
                            pwdata_d  = bus.cmd_wdata;
                            psel_d    = NSLV'(1) << dec_idx;
                            state_nxt = SETUP;
                        end else begin
                            rsp_err_d   = 1'b1;
                            rsp_valid_d = 1'b1;
                            state_nxt   = RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_d = 1'b1;
                    state_nxt = ACCESS;
                end
                ACCESS: begin
                    // A ready slave wins over a timeout reached in the same cycle.
                    if (sel_ready) begin
                        rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                        rsp_err_d   = sel_err;
                        psel_d      = '0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_nxt   = RESP;
                    end else if (to_expired) begin
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        psel_d      = '0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_nxt   = RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_d = 1'b0;
                        state_nxt   = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Qualified by reset_n so cmd_ready reads 0 while reset is held.
    assign bus.cmd_ready = enable & reset_n & (state == IDLE);
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: cycle checks inline, responses checked by a queue-based monitor.
module tb_apb_master;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic pclk;
    logic reset_n;
    logic enable4;
    logic enable3;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t q4[$];
    exp_t q3[$];

    apb_master_if #(.ADDR_W(16), .DATA_W(32), .NSLV(4)) bus4 ();
    apb_master_if #(.ADDR_W(16), .DATA_W(32), .NSLV(3)) bus3 ();

    apb_master #(.ADDR_W(16), .DATA_W(32), .NSLV(4), .TIMEOUT(8)) dut4 (
        .pclk(pclk), .reset_n(reset_n), .enable(enable4), .bus(bus4)
    );

    apb_master #(.ADDR_W(16), .DATA_W(32), .NSLV(3), .TIMEOUT(8)) dut3 (
        .pclk(pclk), .reset_n(reset_n), .enable(enable3), .bus(bus3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_psel"},      bus4.psel,      0);
        check({tag, "_penable"},   bus4.penable,   0);
        check({tag, "_paddr"},     bus4.paddr,     0);
        check({tag, "_pwrite"},    bus4.pwrite,    0);
        check({tag, "_pwdata"},    bus4.pwdata,    0);
        check({tag, "_rsp_valid"}, bus4.rsp_valid, 0);
        check({tag, "_rsp_rdata"}, bus4.rsp_rdata, 0);
        check({tag, "_rsp_err"},   bus4.rsp_err,   0);
        check({tag, "_cmd_ready"}, bus4.cmd_ready, 0);
    endtask

    task automatic cmd4(input logic [15:0] addr, input logic wr, input logic [31:0] wdata);
        bus4.cmd_valid = 1'b1;
        bus4.cmd_addr  = addr;
        bus4.cmd_write = wr;
        bus4.cmd_wdata = wdata;
    endtask

    // Response monitors: every handshake pops one expectation.
    always @(negedge pclk) begin : mon4
        exp_t e;
        if (reset_n && bus4.rsp_valid && bus4.rsp_ready) begin
            if (q4.size() == 0) begin
                n_checks++;
                $display("FAIL rsp4_unexpected: got response rdata 0x%0h err %0b, expected none",
                         bus4.rsp_rdata, bus4.rsp_err);
            end else begin
                e = q4.pop_front();
                check("rsp4_rdata", bus4.rsp_rdata, e.rdata);
                check("rsp4_err",   bus4.rsp_err,   e.err);
            end
        end
    end

    always @(negedge pclk) begin : mon3
        exp_t e;
        if (reset_n && bus3.rsp_valid && bus3.rsp_ready) begin
            if (q3.size() == 0) begin
                n_checks++;
                $display("FAIL rsp3_unexpected: got response rdata 0x%0h err %0b, expected none",
                         bus3.rsp_rdata, bus3.rsp_err);
            end else begin
                e = q3.pop_front();
                check("rsp3_rdata", bus3.rsp_rdata, e.rdata);
                check("rsp3_err",   bus3.rsp_err,   e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        enable4 = 1'b1;
        enable3 = 1'b1;
        bus4.cmd_valid = 0; bus4.cmd_addr = 0; bus4.cmd_write = 0; bus4.cmd_wdata = 0;
        bus4.rsp_ready = 0; bus4.prdata = 0; bus4.pready = 0; bus4.pslverr = 0;
        bus3.cmd_valid = 0; bus3.cmd_addr = 0; bus3.cmd_write = 0; bus3.cmd_wdata = 0;
        bus3.rsp_ready = 0; bus3.prdata = 0; bus3.pready = 0; bus3.pslverr = 0;

        // Reset state
        tick(2);
        check_outputs_zero("reset");
        check("reset3_psel", bus3.psel, 0);
        @(negedge pclk);
        reset_n = 1'b1;
        tick();

        // Zero-wait write to slave 1
        bus4.pready    = 4'hF;
        bus4.rsp_ready = 1'b1;
        q4.push_back('{32'h0, 1'b0});
        cmd4(16'h4004, 1'b1, 32'hDEADBEEF);
        check("t1_cmd_ready", bus4.cmd_ready, 1);
        tick(); bus4.cmd_valid = 1'b0;
        check("t1_c1_psel",    bus4.psel,    4'b0010);
        check("t1_c1_penable", bus4.penable, 0);
        check("t1_c1_pwdata",  bus4.pwdata,  32'hDEADBEEF);
        check("t1_c1_paddr",   bus4.paddr,   16'h4004);
        check("t1_c1_pwrite",  bus4.pwrite,  1);
        tick();
        check("t1_c2_penable", bus4.penable, 1);
        check("t1_c2_psel",    bus4.psel,    4'b0010);
        check("t1_c2_pwdata",  bus4.pwdata,  32'hDEADBEEF);
        tick();
        check("t1_c3_rsp_valid", bus4.rsp_valid, 1);
        check("t1_c3_psel",      bus4.psel,      0);
        check("t1_c3_penable",   bus4.penable,   0);
        tick();
        check("t1_c4_rsp_valid", bus4.rsp_valid, 0);
        check("t1_c4_cmd_ready", bus4.cmd_ready, 1);

        // Read from slave 2 with three wait states
        q4.push_back('{32'h12345678, 1'b0});
        bus4.prdata = 32'h12345678;
        cmd4(16'h8008, 1'b0, 32'h0);
        tick(); bus4.cmd_valid = 1'b0; bus4.pready = 4'b1011;
        check("t2_c1_psel", bus4.psel, 4'b0100);
        tick(3);
        check("t2_c4_penable",   bus4.penable,   1);
        check("t2_c4_paddr",     bus4.paddr,     16'h8008);
        check("t2_c4_rsp_valid", bus4.rsp_valid, 0);
        tick(); bus4.pready = 4'hF;
        check("t2_c5_penable", bus4.penable, 1);
        tick();
        check("t2_c6_rsp_valid", bus4.rsp_valid, 1);
        check("t2_c6_psel",      bus4.psel,      0);
        tick();

        // Slave error on a read of slave 3; read data is still captured
        q4.push_back('{32'h12345678, 1'b1});
        bus4.pslverr = 4'b1000;
        cmd4(16'hC000, 1'b0, 32'h0);
        tick(); bus4.cmd_valid = 1'b0;
        check("t3_c1_psel", bus4.psel, 4'b1000);
        tick(2);
        check("t3_c3_rsp_valid", bus4.rsp_valid, 1);
        check("t3_c3_rsp_err",   bus4.rsp_err,   1);
        tick(); bus4.pslverr = 4'b0000;

        // Response backpressure with a second command waiting
        bus4.rsp_ready = 1'b0;
        q4.push_back('{32'h0, 1'b0});
        cmd4(16'h0010, 1'b1, 32'hA5A5A5A5);
        tick();
        q4.push_back('{32'h0BADF00D, 1'b0});
        bus4.prdata = 32'h0BADF00D;
        cmd4(16'h4000, 1'b0, 32'h0);
        tick(2);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_rsp_valid", bus4.rsp_valid, 1);
            check("t4_hold_rsp_rdata", bus4.rsp_rdata, 0);
            check("t4_hold_cmd_ready", bus4.cmd_ready, 0);
            check("t4_hold_psel",      bus4.psel,      0);
            tick();
        end
        bus4.rsp_ready = 1'b1;
        tick();
        check("t4_next_cmd_ready", bus4.cmd_ready, 1);
        tick(); bus4.cmd_valid = 1'b0;
        check("t4_next_psel", bus4.psel, 4'b0010);
        tick(2);
        check("t4_next_rsp_valid", bus4.rsp_valid, 1);
        tick();

        // Decode error on the three-slave instance
        q3.push_back('{32'h0, 1'b1});
        bus3.rsp_ready = 1'b1;
        bus3.prdata    = 32'hFFFFFFFF;
        bus3.cmd_valid = 1'b1;
        bus3.cmd_addr  = 16'hC000;
        bus3.cmd_write = 1'b0;
        check("t5_cmd_ready", bus3.cmd_ready, 1);
        tick(); bus3.cmd_valid = 1'b0;
        check("t5_c1_psel",      bus3.psel,      3'b000);
        check("t5_c1_rsp_valid", bus3.rsp_valid, 1);
        check("t5_c1_rsp_err",   bus3.rsp_err,   1);
        tick();
        check("t5_c2_rsp_valid", bus3.rsp_valid, 0);

        // enable low freezes the transfer in SETUP
        q4.push_back('{32'h0, 1'b0});
        cmd4(16'h4020, 1'b1, 32'h11223344);
        tick(); bus4.cmd_valid = 1'b0; enable4 = 1'b0;
        tick(3);
        check("t6_frz_psel",      bus4.psel,      4'b0010);
        check("t6_frz_penable",   bus4.penable,   0);
        check("t6_frz_cmd_ready", bus4.cmd_ready, 0);
        enable4 = 1'b1;
        tick();
        check("t6_run_penable", bus4.penable, 1);
        tick();
        check("t6_run_rsp_valid", bus4.rsp_valid, 1);
        tick();

        // Reset during ACCESS drops the command without a response
        bus4.pready = 4'h0;
        cmd4(16'h4000, 1'b0, 32'h00000055);
        tick(); bus4.cmd_valid = 1'b0;
        tick();
        check("t7_access_penable", bus4.penable, 1);
        #2 reset_n = 1'b0;
        #1;
        check_outputs_zero("t7_async");
        @(negedge pclk);
        reset_n = 1'b1;
        bus4.pready = 4'hF;
        tick(3);
        check("t7_after_rsp_valid", bus4.rsp_valid, 0);
        check("t7_after_cmd_ready", bus4.cmd_ready, 1);

        // Slave never ready
        bus4.pready = 4'h0;
        cmd4(16'h8000, 1'b0, 32'h0);
`ifdef APB_MASTER_TIMEOUT_EN
        q4.push_back('{32'h0, 1'b1});
        tick(); bus4.cmd_valid = 1'b0;
        tick(8);
        check("t8_last_access_penable", bus4.penable, 1);
        check("t8_last_access_psel",    bus4.psel,    4'b0100);
        tick();
        check("t8_to_psel",      bus4.psel,      0);
        check("t8_to_penable",   bus4.penable,   0);
        check("t8_to_rsp_valid", bus4.rsp_valid, 1);
        check("t8_to_rsp_err",   bus4.rsp_err,   1);
        tick();
`else
        tick(); bus4.cmd_valid = 1'b0;
        tick(100);
        check("t8_hang_penable",   bus4.penable,   1);
        check("t8_hang_psel",      bus4.psel,      4'b0100);
        check("t8_hang_rsp_valid", bus4.rsp_valid, 0);
        #2 reset_n = 1'b0;
        @(negedge pclk);
        reset_n = 1'b1;
        tick();
`endif

        tick(2);
        check("end_q4_empty", q4.size(), 0);
        check("end_q3_empty", q3.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
